ring_counter_run_controller: RTL
================================

Name: ring_counter_run_controller

Overview:
Sequences one Ring_Counter_8_Bit instance to run for exactly N rotations on request. It resets the counter, pulses Start, counts the observed rotations, and pulses Stop early enough to absorb the counter's stop latency. It then verifies the final one-hot position and reports Done, Match or Error. It sits between a test/control master and the ring counter, and replaces hand-driven Start/Stop stimulus.

Parameters:
STOP_LATENCY, 1, rotations the counter still performs after the cycle Stop_Counter_Command_Out is high
TIMEOUT_CYCLES, 16, maximum cycles to wait for Counter_Running_Flag_In to rise after Start, or to fall after Stop

Ports:
Clk_In  in  1  single clock
Reset_In  in  1  synchronous, active-high reset
Run_Request_In  in  1  request a run; sampled only in IDLE
Run_Length_In  in  8  N, the rotations wanted; sampled with Run_Request_In
Abort_In  in  1  cancel the active run
Run_Ack_Out  out  1  1-cycle pulse when a request is accepted
Busy_Out  out  1  high in every state except IDLE
Done_Out  out  1  1-cycle pulse at end of run
Match_Out  out  1  valid with Done_Out; final count correct
Error_Out  out  1  valid with Done_Out; timeout occurred
Aborted_Out  out  1  valid with Done_Out; run was aborted
Steps_Done_Out  out  8  rotations observed this run; saturates at 8'hFF; held until next accept
Counter_Reset_Out  out  1  drives counter Reset_In
Counter_Enable_Out  out  1  drives counter Enable_In
Start_Counter_Command_Out  out  1  drives counter Start
Stop_Counter_Command_Out  out  1  drives counter Stop
Counter_Running_Flag_In  in  1  from counter
Counter_Count_In  in  8  from counter

Behaviour:
- Reset_In, sampled at posedge: state=IDLE; all outputs 0 except Counter_Reset_Out=1; Steps_Done_Out=0. From the first cycle after reset, Counter_Enable_Out=1 permanently.
- Rotation = any cycle where Counter_Count_In differs from its previous registered value and the new value is one-hot. A non-one-hot change is not counted and sets the internal bad flag (bad forces Match_Out=0).
- IDLE: if Run_Request_In=1 then latch N, pulse Run_Ack_Out, clear Steps and flags.
  - N=0 -> DONE, no counter commands, Match_Out=1.
  - Otherwise -> RESET_CTR.
  - A request in any other state is ignored (no ack).
- RESET_CTR (1 cycle): Counter_Reset_Out=1 -> START.
- START (1 cycle): Start_Counter_Command_Out=1 -> WAIT_RUN; cycle timer cleared.
- WAIT_RUN: on Counter_Running_Flag_In=1 -> COUNT. If the timer reaches TIMEOUT_CYCLES -> ERR.
- COUNT: accumulate rotations. When Steps >= N-STOP_LATENCY (compute as signed; if N<=STOP_LATENCY, go immediately) -> STOP.
- STOP (1 cycle): Stop_Counter_Command_Out=1 -> WAIT_IDLE; timer cleared.
- WAIT_IDLE: keep counting rotations (overshoot is recorded). On running flag=0 -> DONE. On timeout -> ERR.
- ERR (1 cycle): Counter_Reset_Out=1, Error_Out latched -> DONE.
- DONE (1 cycle): Done_Out=1 -> IDLE.
  - Match_Out = (Steps==N) AND (Counter_Count_In == 8'h01 rotated left by N mod 8) AND !bad AND !Error AND !Aborted.
- Abort_In in any busy state except DONE:
  - RESET_CTR/START/WAIT_RUN -> ERR path without the Error flag (Counter_Reset_Out pulse), Aborted_Out=1.
  - COUNT -> STOP, Aborted_Out=1.
  - STOP/WAIT_IDLE: only set Aborted_Out.
- Priority within a cycle: Reset_In > timeout > Abort_In > normal transition.
- Reset mid-run: returns to IDLE next cycle; counter is reset via Counter_Reset_Out; no Done_Out.
- Command outputs are registered; only one of Reset/Start/Stop is high in any cycle.

Decomposition:
- Package ring_counter_ctrl_pkg: state enum (IDLE, RESET_CTR, START, WAIT_RUN, COUNT, STOP, WAIT_IDLE, ERR, DONE), RING_WIDTH=8, RING_RESET_VALUE=8'h01, and the one-hot rotate function used for the expected value.
- Sub-module ring_step_detector: registers Counter_Count_In and outputs step_pulse and not_one_hot. The FSM and counters stay in the top.

Test Plan:
- Request N=5 with a model counter with stop latency 1 -> Ack 1 cycle; Stop pulsed after 4 rotations; Done with Steps_Done_Out=5, Counter_Count_In=8'h20, Match_Out=1.
- N=10 (wrap) -> Done with Steps=10, count 8'h04, Match=1; a second request while Busy gets no Ack.
- N=0 -> Ack, then Done the next cycle; Match=1; Start/Stop/Reset never asserted.
- Counter running flag held 0 -> after 16 WAIT_RUN cycles: Counter_Reset_Out pulse; Done with Error_Out=1, Match=0.
- N=20, Abort_In after 3 rotations -> Stop pulse; Done with Aborted_Out=1, Steps_Done_Out=4, Match=0.
- Reset_In in COUNT at N=8 -> next cycle Busy=0, Counter_Reset_Out=1, no Done; a new N=1 request then completes with Match=1 (count 8'h02).

Source files
------------

// File: rtl/ring_counter_ctrl_pkg.sv
// Shared types and helpers for the ring counter run controller.
// Pure declarations: no latency and no flow control.
package ring_counter_ctrl_pkg;

    localparam int RING_WIDTH = 8;
    localparam logic [RING_WIDTH-1:0] RING_RESET_VALUE = 8'h01;

    typedef enum logic [3:0] {
        IDLE,
        RESET_CTR,
        START,
        WAIT_RUN,
        COUNT,
        STOP,
        WAIT_IDLE,
        ERR,
        DONE
    } ctrl_state_t;

    function automatic logic is_one_hot(input logic [RING_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Position the ring reaches after n rotations from its reset value.
    function automatic logic [RING_WIDTH-1:0] ring_rotl(input logic [7:0] n);
        logic [7:0]              w_idx;
        logic [2*RING_WIDTH-1:0] w_pair;
        w_idx  = n % 8'(RING_WIDTH);
        w_pair = {RING_RESET_VALUE, RING_RESET_VALUE} << w_idx;
        return w_pair[2*RING_WIDTH-1 -: RING_WIDTH];
    endfunction

endpackage

// File: rtl/ring_step_detector.sv
// Flags each change of the ring count as a valid rotation or a corrupt (non-one-hot) value.
// Outputs are combinational against a 1-cycle registered copy; no flow control.
module ring_step_detector
    import ring_counter_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [RING_WIDTH-1:0] i_count,
    output logic                  o_step_pulse,
    output logic                  o_not_one_hot
);

    logic [RING_WIDTH-1:0] r_prev_count;
    logic                  w_changed;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_count <= RING_RESET_VALUE;
        end else begin
            r_prev_count <= i_count;
        end
    end

    assign w_changed     = (i_count != r_prev_count);
    assign o_step_pulse  = w_changed && is_one_hot(i_count);
    assign o_not_one_hot = w_changed && !is_one_hot(i_count);

endmodule

// File: rtl/ring_counter_run_controller.sv
// Runs one ring counter for N rotations: reset, start, count, stop STOP_LATENCY early, then verify.
// Commands and status are registered (1 cycle); requests outside IDLE are dropped without Run_Ack_Out.
module ring_counter_run_controller
    import ring_counter_ctrl_pkg::*;
#(
    parameter int STOP_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Run_Request_In,
    input  logic [7:0]            Run_Length_In,
    input  logic                  Abort_In,
    output logic                  Run_Ack_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic                  Match_Out,
    output logic                  Error_Out,
    output logic                  Aborted_Out,
    output logic [7:0]            Steps_Done_Out,
    output logic                  Counter_Reset_Out,
    output logic                  Counter_Enable_Out,
    output logic                  Start_Counter_Command_Out,
    output logic                  Stop_Counter_Command_Out,
    input  logic                  Counter_Running_Flag_In,
    input  logic [RING_WIDTH-1:0] Counter_Count_In
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    ctrl_state_t r_state;
    logic [7:0]  r_n;
    logic [7:0]  r_steps;
    logic [7:0]  r_timer;
    logic        r_bad;
    logic        r_err;
    logic        r_abort;
    logic        r_run_ack;
    logic        r_busy;
    logic        r_done;
    logic        r_match;
    logic        r_error;
    logic        r_aborted;
    logic        r_ctr_reset;
    logic        r_ctr_enable;
    logic        r_start;
    logic        r_stop;

    logic        w_step;
    logic        w_not_one_hot;
    logic        w_counting;
    logic        w_timeout;
    logic        w_final_match;
    logic [7:0]  w_steps_nxt;

    ring_step_detector u_step_detector (
        .i_clk         (Clk_In),
        .i_reset       (Reset_In),
        .i_count       (Counter_Count_In),
        .o_step_pulse  (w_step),
        .o_not_one_hot (w_not_one_hot)
    );

    // Rotations landing in the Stop cycle or after it are still part of this run.
    assign w_counting    = (r_state == COUNT) || (r_state == STOP) || (r_state == WAIT_IDLE);
    assign w_steps_nxt   = (w_counting && w_step && (r_steps != 8'hFF)) ? r_steps + 8'd1 : r_steps;
    assign w_timeout     = (r_timer == TIMER_LAST);
    assign w_final_match = (r_n == 8'd0) ||
                           ((r_steps == r_n) && (Counter_Count_In == ring_rotl(r_n)) &&
                            !r_bad && !r_err && !r_abort);

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_state      <= IDLE;
            r_n          <= 8'd0;
            r_steps      <= 8'd0;
            r_timer      <= 8'd0;
            r_bad        <= 1'b0;
            r_err        <= 1'b0;
            r_abort      <= 1'b0;
            r_run_ack    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
            r_ctr_reset  <= 1'b1;
            r_ctr_enable <= 1'b0;
            r_start      <= 1'b0;
            r_stop       <= 1'b0;
        end else begin
            r_ctr_enable <= 1'b1;
            r_run_ack    <= 1'b0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
            r_ctr_reset  <= 1'b0;
            r_start      <= 1'b0;
            r_stop       <= 1'b0;
            r_steps      <= w_steps_nxt;
            if (w_counting && w_not_one_hot) begin
                r_bad <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (Run_Request_In) begin
                        r_run_ack <= 1'b1;
                        r_busy    <= 1'b1;
                        r_n       <= Run_Length_In;
                        r_steps   <= 8'd0;
                        r_bad     <= 1'b0;
                        r_err     <= 1'b0;
                        r_abort   <= 1'b0;
                        if (Run_Length_In == 8'd0) begin
                            r_state <= DONE;
                        end else begin
                            r_state     <= RESET_CTR;
                            r_ctr_reset <= 1'b1;
                        end
                    end
                end
                RESET_CTR, START: begin
                    if (Abort_In) begin
                        r_abort     <= 1'b1;
                        r_state     <= ERR;
                        r_ctr_reset <= 1'b1;
                    end else if (r_state == RESET_CTR) begin
                        r_state <= START;
                        r_start <= 1'b1;
                    end else begin
                        r_state <= WAIT_RUN;
                        r_timer <= 8'd0;
                    end
                end
                WAIT_RUN: begin
                    if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_state     <= ERR;
                        r_ctr_reset <= 1'b1;
                    end else if (Abort_In) begin
                        r_abort     <= 1'b1;
                        r_state     <= ERR;
                        r_ctr_reset <= 1'b1;
                    end else if (Counter_Running_Flag_In) begin
                        r_state <= COUNT;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                COUNT: begin
                    if (Abort_In) begin
                        r_abort <= 1'b1;
                        r_state <= STOP;
                        r_stop  <= 1'b1;
                    end else if (int'(w_steps_nxt) >= int'(r_n) - STOP_LATENCY) begin
                        r_state <= STOP;
                        r_stop  <= 1'b1;
                    end
                end
                STOP: begin
                    r_state <= WAIT_IDLE;
                    r_timer <= 8'd0;
                    if (Abort_In) begin
                        r_abort <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_state     <= ERR;
                        r_ctr_reset <= 1'b1;
                    end else begin
                        if (Abort_In) begin
                            r_abort <= 1'b1;
                        end
                        if (!Counter_Running_Flag_In) begin
                            r_state <= DONE;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                end
                ERR: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_match   <= w_final_match;
                    r_error   <= r_err;
                    r_aborted <= r_abort;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Run_Ack_Out               = r_run_ack;
    assign Busy_Out                  = r_busy;
    assign Done_Out                  = r_done;
    assign Match_Out                 = r_match;
    assign Error_Out                 = r_error;
    assign Aborted_Out               = r_aborted;
    assign Steps_Done_Out            = r_steps;
    assign Counter_Reset_Out         = r_ctr_reset;
    assign Counter_Enable_Out        = r_ctr_enable;
    assign Start_Counter_Command_Out = r_start;
    assign Stop_Counter_Command_Out  = r_stop;

endmodule
